// File: rtl/axi4l_sample_fifo_pkg.sv
// Shared constants for the AXI4-Lite sample FIFO: register offsets, bit
// positions, response codes and read-channel states.
package axi4l_sample_fifo_pkg;

  localparam logic [5:0] OFF_DATA   = 6'h00;
  localparam logic [5:0] OFF_COUNT  = 6'h04;
  localparam logic [5:0] OFF_STATUS = 6'h08;
  localparam logic [5:0] OFF_THRESH = 6'h0C;
  localparam logic [5:0] OFF_CTRL   = 6'h20;

  localparam int STAT_EMPTY  = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/axi4l_sample_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A same-address read and write returns the old contents.
module sample_fifo_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4l_sample_fifo.sv
// AXI4-Lite responder that buffers ADC samples and lets software drain them
// through register reads, with a fill-level threshold interrupt.
module axi4l_sample_fifo
  import axi4l_sample_fifo_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int DEPTH      = 1024,
  parameter int THRESH_RST = 512
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [5:0]        s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [5:0]        s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_INIT = CW'(THRESH_RST);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, thresh;
  logic              overflow, irq_en;
  logic              aw_full, w_full, bvalid_q;
  logic [3:0]        aw_word_q;
  logic [31:0]       w_data_q;
  rd_state_e         rd_state, rd_next;
  logic              rd_pop_q;
  logic [31:0]       rd_reg, rd_val;
  logic [DATA_W-1:0] ram_q;
  logic [5:0]        ar_word, wr_word;
  logic              ar_hs, pop, commit, flush, push_ok, drop;

  // Valid/ready: a transfer happens on the rising edge where both are high;
  // a valid, once raised, holds its payload until that edge.
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign ar_word = {s_axi_araddr[5:2], 2'b00};
  assign wr_word = {aw_word_q, 2'b00};
  assign pop     = ar_hs && (ar_word == OFF_DATA) && (count != '0);
  assign commit  = aw_full && w_full && !bvalid_q;
  assign flush   = commit && (wr_word == OFF_CTRL) && w_data_q[CTRL_FLUSH];
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign push_ok = s_valid && !flush && ((count != FULL_CNT) || pop);
  assign drop    = s_valid && !flush && !push_ok;

  sample_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (aclk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (s_data),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

  // Write path: independent address/data holding registers, one commit per pair.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_word_q <= '0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      overflow  <= 1'b0;
      thresh    <= THRESH_INIT;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (s_axi_awvalid && !aw_full) begin
        aw_full   <= 1'b1;
        aw_word_q <= s_axi_awaddr[5:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (s_axi_wvalid && !w_full) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit)            bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
      // A new drop outranks a same-cycle clear so no overflow event is lost.
      if (drop) overflow <= 1'b1;
      else if (commit && wr_word == OFF_STATUS && w_data_q[STAT_OVF]) overflow <= 1'b0;
      if (commit && wr_word == OFF_THRESH) thresh <= w_data_q[CW-1:0];
      if (commit && wr_word == OFF_CTRL)   irq_en <= w_data_q[CTRL_IRQ_EN];
      irq <= irq_en && (thresh != '0) && (count >= thresh);
    end
  end

  always_comb begin
    rd_val = '0;
    case (ar_word)
      OFF_COUNT:  rd_val[CW-1:0] = count;
      OFF_STATUS: begin
        rd_val[STAT_EMPTY] = (count == '0);
        rd_val[STAT_FULL]  = (count == FULL_CNT);
        rd_val[STAT_OVF]   = overflow;
      end
      OFF_THRESH: rd_val[CW-1:0] = thresh;
      OFF_CTRL:   rd_val[CTRL_IRQ_EN] = irq_en;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rd_pop_q <= 1'b0;
      rd_reg   <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rd_pop_q <= pop;
        rd_reg   <= rd_val;
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (s_axi_arvalid) rd_next = RD_RESP;
      RD_RESP: if (s_axi_rready)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // RAM output only changes on a pop, so it stays stable while rvalid is held.
  assign s_axi_rdata   = rd_pop_q ? {{(32-DATA_W){ram_q[DATA_W-1]}}, ram_q} : rd_reg;
  assign s_axi_arready = (rd_state == RD_IDLE);
  assign s_axi_rvalid  = (rd_state == RD_RESP);
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_awready = !aw_full;
  assign s_axi_wready  = !w_full;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr,
                       s_axi_araddr, w_data_q};

endmodule
